seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the board's N-digit seven-segment display.
- Sequences one shared hex-to-segment decoder across all digits: presents one 4-bit digit code at a time and drives the matching active-low anode.
- Inserts a blanking interval between digits to prevent ghosting.
- Double-buffers CPU/debug writes so the display value only changes at frame boundaries (no tearing).

---
 rtl/seg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered display value.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int TICKS_ON    = 1000,
    parameter int TICKS_BLANK = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_mask,
    output logic                    pending,
    output logic                    frame_done,
    output logic [3:0]              seg_digit,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int TICK_MAX = (TICKS_ON > TICKS_BLANK) ? TICKS_ON : TICKS_BLANK;
    localparam int CW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int IW       = $clog2(NUM_DIGITS);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    localparam logic [3:0] BLANK_CODE = 4'hE;

    logic [0:0]              state, state_n;
    logic [IW-1:0]           idx, idx_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [4*NUM_DIGITS-1:0] active_data, shadow_data;
    logic [NUM_DIGITS-1:0]   active_mask, shadow_mask;
    logic [NUM_DIGITS-1:0]   lit;
    logic                    last_tick, wrap;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [3:0]              seg_n;

    assign last_tick = (state == ST_ON) ? (cnt == CW'(TICKS_ON - 1))
                                        : (cnt == CW'(TICKS_BLANK - 1));
    assign wrap      = (state == ST_ON) && last_tick && (idx == IW'(NUM_DIGITS - 1));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + 1'b1;
        if (last_tick) begin
            cnt_n = '0;
            if (state == ST_BLANK) begin
                state_n = ST_ON;
            end else begin
                state_n = ST_BLANK;
                idx_n   = wrap ? '0 : idx + 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit stays lit if it or any more-significant digit holds a nonzero code.
    always_comb begin
        logic seen;
        seen = 1'b0;
        lit  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen   = seen | (active_data[4*i +: 4] != 4'h0);
            lit[i] = seen | (i == 0);
        end
    end
`else
    always_comb begin
        lit = '1;
    end
`endif

    // NOTE: outputs are decoded from the next state so the registered an/seg_digit
    // line up with the state register instead of lagging it by one cycle.
    always_comb begin
        an_n  = '1;
        seg_n = BLANK_CODE;
        if (state_n == ST_ON) begin
            seg_n = active_data[4*idx_n +: 4];
            if (active_mask[idx_n] && lit[idx_n]) begin
                an_n[idx_n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BLANK;
            idx         <= '0;
            cnt         <= '0;
            active_data <= '0;
            active_mask <= '0;
            shadow_data <= '0;
            shadow_mask <= '0;
            pending     <= 1'b0;
            frame_done  <= 1'b0;
            seg_digit   <= BLANK_CODE;
            an          <= '1;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            frame_done <= wrap;
            seg_digit  <= seg_n;
            an         <= an_n;
            if (wr_en) begin
                shadow_data <= wr_data;
                shadow_mask <= wr_mask;
            end
            // A write landing on the wrap cycle bypasses the shadow and commits at once.
            if (wrap) begin
                pending <= 1'b0;
                if (wr_en) begin
                    active_data <= wr_data;
                    active_mask <= wr_mask;
                end else if (pending) begin
                    active_data <= shadow_data;
                    active_mask <= shadow_mask;
                end
            end else if (wr_en) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: frame-position reference model, vector table,
// hand-written corner sequences and randomized writes. Honours SEG_SCAN_LZB_EN.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int TON   = 4;
    localparam int TBL   = 2;
    localparam int SLOT  = TON + TBL;
    localparam int FRAME = N * SLOT;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wr_en = 1'b0;
    logic [4*N-1:0] wr_data = '0;
    logic [N-1:0]   wr_mask = '0;
    logic           pending, frame_done;
    logic [3:0]     seg_digit;
    logic [N-1:0]   an;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_ctrl #(.NUM_DIGITS(N), .TICKS_ON(TON), .TICKS_BLANK(TBL)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .pending    (pending),
        .frame_done (frame_done),
        .seg_digit  (seg_digit),
        .an         (an)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame plus the committed/shadow values.
    int             m_pos;
    logic           m_fd, m_pend;
    logic [4*N-1:0] m_act_d, m_sh_d;
    logic [N-1:0]   m_act_m, m_sh_m;

    always @(posedge clk) begin
        if (reset) begin
            m_pos   <= 0;
            m_fd    <= 1'b0;
            m_pend  <= 1'b0;
            m_act_d <= '0;
            m_act_m <= '0;
            m_sh_d  <= '0;
            m_sh_m  <= '0;
        end else begin
            m_pos <= (m_pos == FRAME - 1) ? 0 : m_pos + 1;
            m_fd  <= (m_pos == FRAME - 1);
            if (wr_en) begin
                m_sh_d <= wr_data;
                m_sh_m <= wr_mask;
            end
            if (m_pos == FRAME - 1) begin
                m_pend <= 1'b0;
                if (wr_en) begin
                    m_act_d <= wr_data;
                    m_act_m <= wr_mask;
                end else if (m_pend) begin
                    m_act_d <= m_sh_d;
                    m_act_m <= m_sh_m;
                end
            end else if (wr_en) begin
                m_pend <= 1'b1;
            end
        end
    end

    function automatic logic m_lit(input int d);
`ifdef SEG_SCAN_LZB_EN
        return (d == 0) || ((m_act_d >> (4 * d)) != 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [3:0] exp_seg();
        int d;
        d = m_pos / SLOT;
        if (m_pos % SLOT < TBL) return 4'hE;
        return 4'((m_act_d >> (4 * d)) & 16'hF);
    endfunction

    function automatic logic [N-1:0] exp_an();
        int d;
        logic [N-1:0] r;
        d = m_pos / SLOT;
        r = '1;
        if ((m_pos % SLOT >= TBL) && m_act_m[d] && m_lit(d)) r[d] = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One clock cycle; outputs compared against the model on the falling edge.
    task automatic tick();
        @(negedge clk);
        check("model_an", 32'(an), 32'(exp_an()));
        check("model_seg", 32'(seg_digit), 32'(exp_seg()));
        check("model_pending", 32'(pending), 32'(m_pend));
        check("model_frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (m_pos == target) return;
            tick();
        end
        check("wait_pos_timeout", 32'(m_pos), 32'(target));
    endtask

    task automatic write(input logic [4*N-1:0] d, input logic [N-1:0] m);
        wr_en   = 1'b1;
        wr_data = d;
        wr_mask = m;
        tick();
        wr_en   = 1'b0;
    endtask

    typedef struct {
        logic [4*N-1:0] data;
        logic [N-1:0]   mask;
        logic [3:0]     seg [N];
        logic [N-1:0]   an  [N];
    } vec_t;

    vec_t vecs [5];
    int   fd_count;

    initial begin
        vecs[0] = '{16'h1234, 4'b1111, '{4'h4, 4'h3, 4'h2, 4'h1}, '{4'b1110, 4'b1101, 4'b1011, 4'b0111}};
        vecs[1] = '{16'hF0F0, 4'b0101, '{4'h0, 4'hF, 4'h0, 4'hF}, '{4'b1110, 4'b1111, 4'b1011, 4'b1111}};
        vecs[4] = '{16'hABCD, 4'b0000, '{4'hD, 4'hC, 4'hB, 4'hA}, '{4'b1111, 4'b1111, 4'b1111, 4'b1111}};
`ifdef SEG_SCAN_LZB_EN
        vecs[2] = '{16'h0042, 4'b1111, '{4'h2, 4'h4, 4'h0, 4'h0}, '{4'b1110, 4'b1101, 4'b1111, 4'b1111}};
        vecs[3] = '{16'h0000, 4'b1111, '{4'h0, 4'h0, 4'h0, 4'h0}, '{4'b1110, 4'b1111, 4'b1111, 4'b1111}};
`else
        vecs[2] = '{16'h0042, 4'b1111, '{4'h2, 4'h4, 4'h0, 4'h0}, '{4'b1110, 4'b1101, 4'b1011, 4'b0111}};
        vecs[3] = '{16'h0000, 4'b1111, '{4'h0, 4'h0, 4'h0, 4'h0}, '{4'b1110, 4'b1101, 4'b1011, 4'b0111}};
`endif

        // Reset values, then an idle stretch of two frames.
        tick();
        tick();
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg_digit), 32'hE);
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_frame_done", 32'(frame_done), 32'h0);
        reset = 1'b0;
        fd_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (frame_done) fd_count++;
            if (an != 4'hF) check("idle_dark", 32'(an), 32'hF);
        end
        check("idle_frame_done_count", 32'(fd_count), 32'd2);

        // Table: write mid-frame, then inspect the following frame digit by digit.
        for (int v = 0; v < 5; v++) begin
            wait_pos(7);
            write(vecs[v].data, vecs[v].mask);
            check("vec_pending_set", 32'(pending), 32'h1);
            wait_pos(0);
            check("vec_commit_frame_done", 32'(frame_done), 32'h1);
            check("vec_commit_pending", 32'(pending), 32'h0);
            for (int d = 0; d < N; d++) begin
                wait_pos(d * SLOT);
                check("vec_blank_an", 32'(an), 32'hF);
                check("vec_blank_seg", 32'(seg_digit), 32'hE);
                wait_pos(d * SLOT + TBL + 1);
                check("vec_seg", 32'(seg_digit), 32'(vecs[v].seg[d]));
                check("vec_an", 32'(an), 32'(vecs[v].an[d]));
            end
        end

        // Two writes in one frame: the last one wins, one frame_done in between.
        wait_pos(5);
        write(16'h1111, 4'b1111);
        wait_pos(9);
        write(16'h2222, 4'b1111);
        fd_count = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (frame_done) fd_count++;
            if (m_pos == TBL + 1) begin
                check("last_write_seg", 32'(seg_digit), 32'h2);
                check("last_write_an", 32'(an), 32'hE);
            end
        end
        check("last_write_fd_count", 32'(fd_count), 32'd1);

        // Write on the exact wrap cycle commits directly.
        wait_pos(FRAME - 1);
        write(16'h5678, 4'b1111);
        check("wrap_write_pending", 32'(pending), 32'h0);
        check("wrap_write_frame_done", 32'(frame_done), 32'h1);
        wait_pos(TBL + 1);
        check("wrap_write_d0", 32'(seg_digit), 32'h8);
        check("wrap_write_an0", 32'(an), 32'hE);
        wait_pos(SLOT + TBL + 1);
        check("wrap_write_d1", 32'(seg_digit), 32'h7);

        // Reset mid-ON of digit 2 with a write still pending.
        wait_pos(2 * SLOT + 1);
        write(16'h4321, 4'b1111);
        check("pre_reset_pending", 32'(pending), 32'h1);
        wait_pos(2 * SLOT + TBL + 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_an", 32'(an), 32'hF);
        check("mid_reset_seg", 32'(seg_digit), 32'hE);
        check("mid_reset_pending", 32'(pending), 32'h0);
        wait_pos(TBL + 1);
        check("post_reset_dark", 32'(an), 32'hF);
        wait_pos(0);
        wait_pos(TBL + 1);
        check("shadow_lost", 32'(an), 32'hF);

        // Randomized writes at random times, checked every cycle by the model.
        for (int i = 0; i < 40 * FRAME; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                write(16'($urandom), 4'($urandom));
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
